// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP48A1 MAC sequencer.
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // OPMODE encodings: X=M,Z=0 for the first product, X=M,Z=P to accumulate.
  localparam logic [7:0] OPM_IDLE = 8'h00;
  localparam logic [7:0] OPM_MUL  = 8'h01;
  localparam logic [7:0] OPM_MAC  = 8'h09;

  // One tag per slice register stage after the A/B inputs (M, P, result).
  localparam int unsigned TAG_DEPTH = 3;

  typedef struct packed {
    logic valid;
    logic first;
  } tag_t;

endpackage

// File: rtl/dsp_seq_tag_pipe.sv
// Tracks each issued operand pair through the slice's M and P stages and
// derives the per-stage clock enables and OPMODE from it.
module dsp_seq_tag_pipe
  import dsp_seq_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       issue_i,
  input  logic       first_i,
  output logic       ce_m_o,
  output logic       ce_p_o,
  output logic [7:0] opmode_o,
  output logic       pending_o,
  output logic       done_o
);

  tag_t [TAG_DEPTH-1:0] tag_q;

  // Shift a {valid, first} tag per cycle; bubbles enter as empty tags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_q <= '0;
    end else begin
      tag_q[0].valid <= issue_i;
      tag_q[0].first <= issue_i && first_i;
      for (int unsigned i = 1; i < TAG_DEPTH; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign ce_m_o    = tag_q[0].valid;
  assign ce_p_o    = tag_q[1].valid;
  assign pending_o = tag_q[0].valid || tag_q[1].valid;
  assign done_o    = tag_q[TAG_DEPTH-1].valid;

  // OPMODE follows the tag sitting at the P stage.
  always_comb begin
    opmode_o = OPM_IDLE;
    if (tag_q[1].valid) begin
      opmode_o = tag_q[1].first ? OPM_MUL : OPM_MAC;
    end
  end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Runs one DSP48A1 slice (AREG=BREG=MREG=PREG=1) as a MAC engine: pulls
// len operand pairs, accumulates their products and reports the sum.
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int A_BITS   = 18,
  parameter int B_BITS   = 18,
  parameter int P_BITS   = 48,
  parameter int LEN_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_BITS-1:0] len,
  output logic                busy,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [A_BITS-1:0]   a_in,
  input  logic [B_BITS-1:0]   b_in,
  output logic [A_BITS-1:0]   dsp_a,
  output logic [B_BITS-1:0]   dsp_b,
  output logic                dsp_ce_ab,
  output logic                dsp_ce_m,
  output logic                dsp_ce_p,
  output logic [7:0]          dsp_opmode,
  input  logic [P_BITS-1:0]   dsp_p,
  output logic [P_BITS-1:0]   result,
  output logic                result_valid
);

  state_t              state_q;
  logic [LEN_BITS-1:0] len_q;
  logic [LEN_BITS-1:0] cnt_q;
  logic [LEN_BITS-1:0] cnt_d;
  logic [P_BITS-1:0]   result_q;
  logic                result_valid_q;
  logic                issue;
  logic                first_issue;
  logic                tag_pending;
  logic                tag_done;

  assign dsp_a       = a_in;
  assign dsp_b       = b_in;
  assign op_ready    = (state_q == RUN);
  assign busy        = (state_q != IDLE);
  assign issue       = op_valid && op_ready;
  assign first_issue = (cnt_q == '0);
  assign cnt_d       = cnt_q + LEN_BITS'(1);
  assign dsp_ce_ab   = issue;

  dsp_seq_tag_pipe u_tag_pipe (
    .clk_i     (clk),
    .rst_i     (rst),
    .issue_i   (issue),
    .first_i   (first_issue),
    .ce_m_o    (dsp_ce_m),
    .ce_p_o    (dsp_ce_p),
    .opmode_o  (dsp_opmode),
    .pending_o (tag_pending),
    .done_o    (tag_done)
  );

  // Job control: accept a job, count transfers, then capture P once the
  // last product has left the P stage (only the final tag remains).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      len_q          <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              len_q   <= len;
              cnt_q   <= '0;
              state_q <= RUN;
            end else begin
              result_q       <= '0;
              result_valid_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            cnt_q <= cnt_d;
            if (cnt_d == len_q) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (tag_done && !tag_pending) begin
            result_q       <= dsp_p;
            result_valid_q <= 1'b1;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Scoreboard bench for dsp_mac_sequencer with a behavioural DSP48A1 slice.
module tb_dsp_mac_sequencer;

  localparam int A_BITS   = 18;
  localparam int B_BITS   = 18;
  localparam int P_BITS   = 48;
  localparam int LEN_BITS = 8;

  logic                clk;
  logic                rst;
  logic                start;
  logic [LEN_BITS-1:0] len;
  logic                busy;
  logic                op_valid;
  logic                op_ready;
  logic [A_BITS-1:0]   a_in;
  logic [B_BITS-1:0]   b_in;
  logic [A_BITS-1:0]   dsp_a;
  logic [B_BITS-1:0]   dsp_b;
  logic                dsp_ce_ab;
  logic                dsp_ce_m;
  logic                dsp_ce_p;
  logic [7:0]          dsp_opmode;
  logic [P_BITS-1:0]   dsp_p;
  logic [P_BITS-1:0]   result;
  logic                result_valid;

  dsp_mac_sequencer #(
    .A_BITS  (A_BITS),
    .B_BITS  (B_BITS),
    .P_BITS  (P_BITS),
    .LEN_BITS(LEN_BITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len         (len),
    .busy        (busy),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .dsp_a       (dsp_a),
    .dsp_b       (dsp_b),
    .dsp_ce_ab   (dsp_ce_ab),
    .dsp_ce_m    (dsp_ce_m),
    .dsp_ce_p    (dsp_ce_p),
    .dsp_opmode  (dsp_opmode),
    .dsp_p       (dsp_p),
    .result      (result),
    .result_valid(result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural slice: A/B, M and P registers with per-stage enables.
  logic signed [A_BITS-1:0]        areg;
  logic signed [B_BITS-1:0]        breg;
  logic signed [A_BITS+B_BITS-1:0] prod;
  logic [P_BITS-1:0]               mreg;
  logic [P_BITS-1:0]               preg;
  initial begin
    areg = '0; breg = '0; mreg = '0; preg = '0;
  end
  assign prod  = areg * breg;
  assign dsp_p = preg;
  always @(posedge clk) begin
    if (dsp_ce_ab) begin
      areg <= dsp_a;
      breg <= dsp_b;
    end
    if (dsp_ce_m) mreg <= {{(P_BITS-A_BITS-B_BITS){prod[A_BITS+B_BITS-1]}}, prod};
    if (dsp_ce_p) preg <= ((dsp_opmode[1:0] == 2'b01) ? mreg : '0)
                        + ((dsp_opmode[3:2] == 2'b10) ? preg : '0);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  typedef struct {
    logic [P_BITS-1:0] val;
    bit                chk_lat;
  } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Monitor: per-cycle enable/opmode timing and result scoreboard.
  int       last_issue = 0;
  int       job_issues = 0;
  bit [1:0] ab_hist    = '0;
  bit [1:0] first_hist = '0;
  bit       rv_prev    = 1'b0;
  always @(negedge clk) begin
    bit   iss;
    exp_t e;
    if (rst) begin
      ab_hist    = '0;
      first_hist = '0;
      rv_prev    = 1'b0;
    end else begin
      iss = op_valid && op_ready;
      chk("ce_ab", {63'd0, dsp_ce_ab}, {63'd0, iss});
      chk("ce_m", {63'd0, dsp_ce_m}, {63'd0, ab_hist[0]});
      chk("ce_p", {63'd0, dsp_ce_p}, {63'd0, ab_hist[1]});
      chk("opmode", {56'd0, dsp_opmode},
          {56'd0, ab_hist[1] ? (first_hist[1] ? 8'h01 : 8'h09) : 8'h00});
      if (result_valid) begin
        chk("rv_pulse", {63'd0, rv_prev}, 64'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_result_valid", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result", {16'd0, result}, {16'd0, e.val});
          if (e.chk_lat) chk("rv_latency", 64'(cyc - last_issue), 64'd4);
        end
      end
      rv_prev    = result_valid;
      ab_hist    = {ab_hist[0], iss};
      first_hist = {first_hist[0], iss && (job_issues == 0)};
      if (iss) begin
        last_issue = cyc;
        job_issues = job_issues + 1;
      end
    end
  end

  task automatic start_job(input int n);
    @(posedge clk); #1;
    start      = 1'b1;
    len        = LEN_BITS'(n);
    job_issues = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pair(input int a, input int b);
    bit done;
    done     = 1'b0;
    op_valid = 1'b1;
    a_in     = A_BITS'(a);
    b_in     = B_BITS'(b);
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (op_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) chk("ready_timeout", 64'd0, 64'd1);
    op_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic after_last();
    @(negedge clk);
    chk("ready_drop", {63'd0, op_ready}, 64'd0);
    chk("busy_drain", {63'd0, busy}, 64'd1);
    wait_idle();
  endtask

  task automatic run_job(input int n, input int av[4], input int bv[4],
                         input int gap, input logic [P_BITS-1:0] expv);
    exp_q.push_back('{expv, 1'b1});
    start_job(n);
    for (int i = 0; i < n; i++) begin
      send_pair(av[i], bv[i]);
      if (i < n - 1) repeat (gap) begin @(posedge clk); #1; end
    end
    after_last();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; op_valid = 1'b0;
    a_in = 18'h1234; b_in = 18'h2abcd;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready", {63'd0, op_ready}, 64'd0);
    chk("rst_ces", {61'd0, dsp_ce_ab, dsp_ce_m, dsp_ce_p}, 64'd0);
    chk("rst_opmode", {56'd0, dsp_opmode}, 64'd0);
    chk("rst_result", {16'd0, result}, 64'd0);
    chk("rst_rv", {63'd0, result_valid}, 64'd0);
    chk("dsp_a_copy", {46'd0, dsp_a}, 64'h1234);
    chk("dsp_b_copy", {46'd0, dsp_b}, 64'h2abcd);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: back-to-back job, 2*5+3*6+4*7 = 56
    run_job(3, '{2, 3, 4, 0}, '{5, 6, 7, 0}, 0, 48'd56);
    // 2: same job with two bubble cycles between pairs
    run_job(3, '{2, 3, 4, 0}, '{5, 6, 7, 0}, 2, 48'd56);
    // 3: single signed product, -3*100 = -300
    run_job(1, '{-3, 0, 0, 0}, '{100, 0, 0, 0}, 0, 48'hFFFF_FFFF_FED4);

    // 4: zero-length job, op_valid held high to expose any stray ready
    exp_q.push_back('{48'd0, 1'b0});
    op_valid = 1'b1;
    start_job(0);
    @(negedge clk);
    chk("len0_rv", {63'd0, result_valid}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      chk("len0_busy", {63'd0, busy}, 64'd0);
      chk("len0_ready", {63'd0, op_ready}, 64'd0);
      chk("len0_ces", {61'd0, dsp_ce_ab, dsp_ce_m, dsp_ce_p}, 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    op_valid = 1'b0;

    // 5: start during RUN is ignored; next job starts with Z=0
    exp_q.push_back('{48'd20, 1'b1});
    start_job(2);
    start = 1'b1;
    len   = 8'd7;
    send_pair(1, 10);
    start = 1'b0;
    send_pair(1, 10);
    after_last();
    run_job(1, '{5, 0, 0, 0}, '{5, 0, 0, 0}, 0, 48'd25);

    // 6: reset after first of three transfers
    start_job(3);
    send_pair(2, 5);
    op_valid = 1'b1;
    a_in = 18'd3; b_in = 18'd6;
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_ready", {63'd0, op_ready}, 64'd0);
    chk("midrst_ces", {61'd0, dsp_ce_ab, dsp_ce_m, dsp_ce_p}, 64'd0);
    chk("midrst_opmode", {56'd0, dsp_opmode}, 64'd0);
    chk("midrst_result", {16'd0, result}, 64'd0);
    chk("midrst_rv", {63'd0, result_valid}, 64'd0);
    op_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_job(3, '{2, 3, 4, 0}, '{5, 6, 7, 0}, 0, 48'd56);

    // Maximum length job: 255 pairs of 1*1 -> 255
    exp_q.push_back('{48'd255, 1'b1});
    start_job(255);
    for (int i = 0; i < 255; i++) send_pair(1, 1);
    after_last();

    repeat (5) @(posedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Controller that runs one DSP48A1-style slice as a multiply-accumulate engine.
- Accepts a job (start + length), pulls operand pairs over a valid/ready stream, and drives the slice's clock enables and OPMODE so that P = sum of A*B over the job.
- Captures the final P and presents it with a one-cycle result_valid pulse.
- Sits between the operand source and a slice configured as AREG=BREG=MREG=PREG=1, OPMODEREG=0, with registers enabled per stage.

Parameters:
- A_BITS, 18, signed A operand width
- B_BITS, 18, signed B operand width
- P_BITS, 48, accumulator/result width
- LEN_BITS, 8, width of job length field

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  job request; sampled only in IDLE
- len  in  LEN_BITS  number of operand pairs, sampled with start
- busy  out  1  high in RUN and DRAIN
- op_valid  in  1  operand pair valid
- op_ready  out  1  sequencer accepts a pair
- a_in  in  A_BITS  operand A
- b_in  in  B_BITS  operand B
- dsp_a  out  A_BITS  to slice A input (continuous copy of a_in)
- dsp_b  out  B_BITS  to slice B input (continuous copy of b_in)
- dsp_ce_ab  out  1  A/B register enable
- dsp_ce_m  out  1  M register enable
- dsp_ce_p  out  1  P register enable
- dsp_opmode  out  8  slice OPMODE
- dsp_p  in  P_BITS  slice P output
- result  out  P_BITS  captured sum
- result_valid  out  1  one-cycle pulse when result updates

Behaviour:

Reset (asynchronous): state IDLE. All outputs 0 except dsp_a/dsp_b, which are wires. Tag pipe cleared and counters cleared.

Handshake:
- A transfer ("issue") occurs when op_valid && op_ready.
- op_ready = 1 only in RUN.
- dsp_ce_ab = issue, in the same cycle.

Tag pipe (3 stages): on issue at cycle t:
- dsp_ce_m = 1 at t+1.
- dsp_ce_p = 1 at t+2.
- dsp_opmode at t+2:
  - 0x01 (X=M, Z=0) if this is the job's first issue.
  - 0x09 (X=M, Z=P) otherwise.
- dsp_opmode = 0x00 whenever the P stage tag is empty.
- Bubbles (op_valid low) propagate as empty tags, so the corresponding CE stays low and M/P hold.

States:
- IDLE
  - start && len!=0: latch len, clear issue count, go to RUN.
  - start && len==0: result <= 0, result_valid=1 next cycle, stay IDLE. No DSP enables.
- RUN: count issues. The issue that makes count==len moves state to DRAIN on the next edge, so op_ready drops immediately after the last transfer.
- DRAIN
  - Wait until the tag pipe is empty; the last dsp_ce_p is at t_last+2.
  - At t_last+3, dsp_p holds the final sum: capture it into result.
  - result_valid is high during t_last+4.
  - State returns to IDLE at that same edge, so start is accepted from t_last+4.

Arithmetic: 18x18 signed product, sign-extended to P_BITS inside the slice. The accumulator wraps modulo 2^P_BITS, with no overflow detection. The first issue of each job uses Z=0, so stale P never leaks between jobs.

Boundaries:
- start while busy: ignored.
- len at maximum 2^LEN_BITS-1: supported.
- result holds its value until the next capture.
- rst mid-job: job abandoned, no result_valid, outputs 0 immediately.

Decomposition:
- Package dsp_seq_pkg:
  - state enum {IDLE, RUN, DRAIN}
  - OPM_IDLE=8'h00, OPM_MUL=8'h01, OPM_MAC=8'h09
  - tag pipe depth constant TAG_DEPTH=3
- One sub-module, dsp_seq_tag_pipe: 3-stage {valid, first} shift register with async reset. It generates ce_m, ce_p and opmode.

Test Plan:
1. len=3, A=(2,3,4), B=(5,6,7), op_valid held high.
   - Required: ce_ab high for 3 cycles, ce_p at t+2..t+4.
   - Opmode sequence 01,09,09; result=56; result_valid exactly 4 cycles after the last transfer.
2. Same job with op_valid low for 2 cycles between each pair.
   - Required: ce_m/ce_p low in the matching bubble cycles, opmode 00 there.
   - result=56.
3. len=1, A=-3, B=100.
   - Required: result=48'hFFFF_FFFF_FED4 (-300), opmode 01 only.
4. len=0.
   - Required: result=0, result_valid pulse next cycle, op_ready and all CEs never asserted, busy stays 0.
5. Job (len=2, A=(1,1), B=(10,10)) gives result=20.
   - start pulsed during RUN of that job is ignored.
   - A second job with len=1, A=5, B=5 gives result=25, not 45: the first opmode is 01.
6. Assert rst during RUN after 1 of 3 transfers.
   - Required: immediately busy=0, op_ready=0, CEs=0, result=0, no result_valid.
   - After release, job 1 gives result=56.
